tft_spi_receiver: RTL and testbench
===================================

Name: tft_spi_receiver

Overview:
Slave-side receiver for the TFT SPI link. It captures the serial command/data stream that the TFT SPI transmitter drives on SPI_CLK, SPI_MOSI, SPI_CS and RS, and rebuilds the 16-bit words together with their RS (command/data) flag. Words are buffered in a small FIFO and handed to the system side with a valid/ready handshake. Used for loopback checking of the display path and as the front end of an on-chip display model.

Parameters:
WordBits, 16, bits per SPI word, sent MSB first.
FifoDepth, 4, FIFO entries; must be a power of two.
FifoAddrBits, 2, log2(FifoDepth).

Ports:
MasterCLK  input  1  system clock; must run at least 4x the SPI_CLK frequency.
Reset  input  1  asynchronous, active-high reset.
SPI_CLK  input  1  serial clock from the transmitter; asynchronous to MasterCLK.
SPI_MOSI  input  1  serial data, sampled on the SPI_CLK rising edge.
SPI_CS  input  1  chip select, active low.
RS  input  1  0 = command, 1 = data; sampled with the last bit of each word.
OutData  output  WordBits  received word at the FIFO head.
OutRS  output  1  RS flag of the word at the FIFO head.
OutValid  output  1  FIFO not empty.
OutReady  input  1  consumer accepts the head word when OutValid and OutReady are both high.
Overflow  output  1  sticky: a completed word was dropped because the FIFO was full.
FrameError  output  1  sticky: SPI_CS deasserted in the middle of a word.
ClearErr  input  1  synchronous clear of Overflow and FrameError.
WordCount  output  16  count of words accepted into the FIFO; wraps from 0xFFFF to 0.

Behaviour:
- Reset (asynchronous): all outputs 0. Synchronizer flops reset to the idle pin state (CLK=0, MOSI=0, CS=1, RS=0). Bit counter 0, shift register 0, FIFO empty.
- Synchronization: SPI_CLK, SPI_MOSI, SPI_CS and RS each pass through 2 flops, then 1 history flop for SPI_CLK and SPI_CS. "Rise" = synced CLK is 1 and the history flop is 0.
- Shift: on a Rise with synced CS low, shift = {shift[WordBits-2:0], MOSI_s} and bitcnt increments.
- Word completion: on the Rise where bitcnt = WordBits-1, the next shift value and RS_s are pushed to the FIFO in that same MasterCLK edge, and bitcnt goes to 0. OutValid rises in the next cycle if the FIFO was empty. Latency from the raw pin edge to OutValid is 3–4 MasterCLK cycles.
- A Rise while synced CS is high is ignored.
- CS handling:
  - A CS rising edge with bitcnt ≠ 0 sets FrameError, discards the partial word and zeroes bitcnt.
  - A CS rising edge with bitcnt = 0 is normal and has no effect.
  - Words may run back-to-back under one CS low period; the bit counter alone delimits words.
- FIFO:
  - First-word fall-through: OutData and OutRS show the head entry whenever OutValid is high.
  - Pop when OutValid and OutReady.
  - Push while full without a pop in the same cycle: the word is dropped, Overflow is set and WordCount does not change.
  - Push and pop in the same cycle while full: both happen, no overflow.
  - Push and pop in the same cycle while empty: push only (OutValid was low, so no pop).
  - Occupancy counter is FifoAddrBits+1 wide; read and write pointers wrap modulo FifoDepth.
- WordCount increments on every successful push.
- ClearErr has priority over a same-cycle set: both flags read 0 in the next cycle.
- Reset asserted mid-word discards the partial word and all FIFO contents.

Decomposition:
- Shared constants header: default WordBits, the RS encoding (RS_CMD=0, RS_DATA=1) and the CS active level, so the transmitter and receiver use the same definitions.
- One sub-module, sync_fifo, parameterized by width (WordBits+1) and depth. It provides push, pop, full, empty and dout.
- Synchronizers, edge detection, deserializer and error flags stay in the top module.

Test Plan:
- Single data word: CS low, RS=1, send 0xA55A MSB first at MasterCLK/8, CS high → one word with OutData=0xA55A, OutRS=1, WordCount=1, no error flags.
- Back-to-back under one CS: command 0x002A (RS=0) then data 0x1234 (RS=1), OutReady=1 → words popped in order with OutRS 0 then 1; WordCount=2.
- Overflow: OutReady=0, send 5 words 0x0001..0x0005 → FIFO holds 0x0001..0x0004, Overflow=1, WordCount=4. Then OutReady=1 → those four words drain in order and OutValid falls.
- Aborted frame: send 7 bits, then raise CS → FrameError=1, no push. The next full word 0xBEEF is received intact. ClearErr pulse → FrameError=0.
- Clocks while deselected: 16 SPI_CLK pulses with CS high → no push, bitcnt stays 0, outputs unchanged.
- Reset mid-word: assert Reset after 9 bits with 2 words queued → OutValid=0 and WordCount=0 at once. A fresh word 0x00FF is then received correctly.

Source files
------------

// File: rtl/tft_spi_receiver_pkg.sv
// tft_spi_receiver_pkg: definitions shared by the TFT SPI transmitter and receiver.
// Holds the default word width, FIFO sizing, the RS (command/data) encoding,
// the chip-select active level and the idle level of every link pin.
package tft_spi_receiver_pkg;

    localparam int WORD_BITS      = 16;
    localparam int FIFO_DEPTH     = 4;
    localparam int FIFO_ADDR_BITS = 2;

    localparam logic RS_CMD    = 1'b0;
    localparam logic RS_DATA   = 1'b1;
    localparam logic CS_ACTIVE = 1'b0;

    localparam logic SPI_CLK_IDLE  = 1'b0;
    localparam logic SPI_MOSI_IDLE = 1'b0;
    localparam logic SPI_CS_IDLE   = ~CS_ACTIVE;
    localparam logic RS_IDLE       = RS_CMD;

    function automatic logic cs_selected(input logic cs);
        return cs == CS_ACTIVE;
    endfunction

endpackage

// File: rtl/tft_spi_receiver_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO.
// Ports: clk_i/rst_i (async active-high reset), push_i/din_i write side,
// pop_i read side (ignored when empty), full_o/empty_o status, and dout_o,
// which shows the head entry whenever the FIFO is not empty and 0 otherwise.
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int Width    = 17,
    parameter int Depth    = 4,
    parameter int AddrBits = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [Width-1:0] din_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [Width-1:0] dout_o
);

    logic [Width-1:0]  mem_q [Depth];
    logic [AddrBits-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AddrBits:0]   count_q, count_d;
    logic do_push, do_pop;

    assign empty_o = count_q == '0;
    assign full_o  = count_q == (AddrBits + 1)'(Depth);
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // Pointers are exactly AddrBits wide, so they wrap modulo Depth on their own.
    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + (AddrBits + 1)'(do_push) - (AddrBits + 1)'(do_pop);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: dout_o is masked while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/tft_spi_receiver.sv
// tft_spi_receiver: slave-side deserializer for the TFT SPI link.
// Ports: MasterCLK system clock; Reset async active-high; SPI_CLK/SPI_MOSI/
// SPI_CS/RS raw link pins (asynchronous to MasterCLK); OutData/OutRS/OutValid
// head of the receive FIFO, consumed with OutReady; Overflow and FrameError
// sticky error flags cleared by ClearErr; WordCount counts accepted words.
module tft_spi_receiver
    import tft_spi_receiver_pkg::*;
#(
    parameter int WordBits     = WORD_BITS,
    parameter int FifoDepth    = FIFO_DEPTH,
    parameter int FifoAddrBits = FIFO_ADDR_BITS
) (
    input  logic                MasterCLK,
    input  logic                Reset,
    input  logic                SPI_CLK,
    input  logic                SPI_MOSI,
    input  logic                SPI_CS,
    input  logic                RS,
    output logic [WordBits-1:0] OutData,
    output logic                OutRS,
    output logic                OutValid,
    input  logic                OutReady,
    output logic                Overflow,
    output logic                FrameError,
    input  logic                ClearErr,
    output logic [15:0]         WordCount
);

    localparam int CntBits = $clog2(WordBits);

    logic clk_meta_q, clk_s_q, clk_h_q;
    logic mosi_meta_q, mosi_s_q;
    logic cs_meta_q, cs_s_q, cs_h_q;
    logic rs_meta_q, rs_s_q;

    logic [WordBits-1:0] shift_q, shift_d, shift_nxt;
    logic [CntBits-1:0]  bitcnt_q, bitcnt_d;
    logic                overflow_q, overflow_d, frame_q, frame_d;
    logic [15:0]         wcount_q, wcount_d;

    logic rise, cs_deselect, last_bit, push, frame_set;
    logic fifo_full, fifo_empty, pop, ovf_set, accept;
    logic [WordBits:0] fifo_dout;

    // Two-flop synchronizers; CLK and CS get a third history flop for edge detection.
    always_ff @(posedge MasterCLK or posedge Reset) begin
        if (Reset) begin
            clk_meta_q  <= SPI_CLK_IDLE;
            clk_s_q     <= SPI_CLK_IDLE;
            clk_h_q     <= SPI_CLK_IDLE;
            mosi_meta_q <= SPI_MOSI_IDLE;
            mosi_s_q    <= SPI_MOSI_IDLE;
            cs_meta_q   <= SPI_CS_IDLE;
            cs_s_q      <= SPI_CS_IDLE;
            cs_h_q      <= SPI_CS_IDLE;
            rs_meta_q   <= RS_IDLE;
            rs_s_q      <= RS_IDLE;
        end else begin
            clk_meta_q  <= SPI_CLK;
            clk_s_q     <= clk_meta_q;
            clk_h_q     <= clk_s_q;
            mosi_meta_q <= SPI_MOSI;
            mosi_s_q    <= mosi_meta_q;
            cs_meta_q   <= SPI_CS;
            cs_s_q      <= cs_meta_q;
            cs_h_q      <= cs_s_q;
            rs_meta_q   <= RS;
            rs_s_q      <= rs_meta_q;
        end
    end

    assign rise        = clk_s_q & ~clk_h_q;
    assign cs_deselect = !cs_selected(cs_s_q) && cs_selected(cs_h_q);
    assign last_bit    = bitcnt_q == CntBits'(WordBits - 1);
    assign shift_nxt   = {shift_q[WordBits-2:0], mosi_s_q};

    // A deselect edge cannot coincide with an accepted rise, since the rise
    // needs CS selected, so the two branches are mutually exclusive.
    always_comb begin
        shift_d   = shift_q;
        bitcnt_d  = bitcnt_q;
        push      = 1'b0;
        frame_set = 1'b0;
        if (rise && cs_selected(cs_s_q)) begin
            shift_d  = shift_nxt;
            bitcnt_d = last_bit ? '0 : bitcnt_q + 1'b1;
            push     = last_bit;
        end else if (cs_deselect && bitcnt_q != '0) begin
            shift_d   = '0;
            bitcnt_d  = '0;
            frame_set = 1'b1;
        end
    end

    // A full FIFO only takes the new word if the head leaves in the same cycle.
    assign pop      = ~fifo_empty & OutReady;
    assign ovf_set  = push & fifo_full & ~pop;
    assign accept   = push & ~ovf_set;

    always_comb begin
        overflow_d = ClearErr ? 1'b0 : overflow_q | ovf_set;
        frame_d    = ClearErr ? 1'b0 : frame_q | frame_set;
        wcount_d   = accept ? wcount_q + 16'd1 : wcount_q;
    end

    always_ff @(posedge MasterCLK or posedge Reset) begin
        if (Reset) begin
            shift_q    <= '0;
            bitcnt_q   <= '0;
            overflow_q <= 1'b0;
            frame_q    <= 1'b0;
            wcount_q   <= '0;
        end else begin
            shift_q    <= shift_d;
            bitcnt_q   <= bitcnt_d;
            overflow_q <= overflow_d;
            frame_q    <= frame_d;
            wcount_q   <= wcount_d;
        end
    end

    sync_fifo #(
        .Width    (WordBits + 1),
        .Depth    (FifoDepth),
        .AddrBits (FifoAddrBits)
    ) u_fifo (
        .clk_i   (MasterCLK),
        .rst_i   (Reset),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   ({rs_s_q, shift_nxt}),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .dout_o  (fifo_dout)
    );

    assign OutData    = fifo_dout[WordBits-1:0];
    assign OutRS      = fifo_dout[WordBits];
    assign OutValid   = ~fifo_empty;
    assign Overflow   = overflow_q;
    assign FrameError = frame_q;
    assign WordCount  = wcount_q;

endmodule

// File: tb/tb_tft_spi_receiver.sv
// tb_tft_spi_receiver: directed bench for tft_spi_receiver; SPI runs at MasterCLK/8.
module tb_tft_spi_receiver;

    logic        MasterCLK = 1'b0;
    logic        Reset = 1'b1;
    logic        SPI_CLK = 1'b0;
    logic        SPI_MOSI = 1'b0;
    logic        SPI_CS = 1'b1;
    logic        RS = 1'b0;
    logic [15:0] OutData;
    logic        OutRS;
    logic        OutValid;
    logic        OutReady = 1'b0;
    logic        Overflow;
    logic        FrameError;
    logic        ClearErr = 1'b0;
    logic [15:0] WordCount;

    int total = 0;
    int bad = 0;

    tft_spi_receiver dut (
        .MasterCLK  (MasterCLK),
        .Reset      (Reset),
        .SPI_CLK    (SPI_CLK),
        .SPI_MOSI   (SPI_MOSI),
        .SPI_CS     (SPI_CS),
        .RS         (RS),
        .OutData    (OutData),
        .OutRS      (OutRS),
        .OutValid   (OutValid),
        .OutReady   (OutReady),
        .Overflow   (Overflow),
        .FrameError (FrameError),
        .ClearErr   (ClearErr),
        .WordCount  (WordCount)
    );

    always #5 MasterCLK = ~MasterCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge MasterCLK);
    endtask

    task automatic spi_bit(input logic b);
        SPI_MOSI = b;
        SPI_CLK = 1'b0;
        cycles(4);
        SPI_CLK = 1'b1;
        cycles(4);
    endtask

    task automatic send_bits(input logic [15:0] w, input logic rs, input int n);
        RS = rs;
        for (int i = 0; i < n; i++) spi_bit(w[15-i]);
    endtask

    task automatic frame(input logic [15:0] w, input logic rs);
        SPI_CS = 1'b0;
        send_bits(w, rs, 16);
        SPI_CLK = 1'b0;
        SPI_CS = 1'b1;
        cycles(6);
    endtask

    task automatic pop_word();
        OutReady = 1'b1;
        cycles(1);
        OutReady = 1'b0;
    endtask

    task automatic clear_err();
        ClearErr = 1'b1;
        cycles(1);
        ClearErr = 1'b0;
    endtask

    initial begin
        cycles(3);
        chk("rst_valid", OutValid, 0);
        chk("rst_data", OutData, 0);
        chk("rst_rs", OutRS, 0);
        chk("rst_ovf", Overflow, 0);
        chk("rst_ferr", FrameError, 0);
        chk("rst_wc", WordCount, 0);
        Reset = 1'b0;
        cycles(2);

        // single data word with latency check on the final bit
        SPI_CS = 1'b0;
        send_bits(16'hA55A, 1'b1, 15);
        SPI_MOSI = 1'b0;
        SPI_CLK = 1'b0;
        cycles(4);
        SPI_CLK = 1'b1;
        cycles(2);
        chk("lat_early", OutValid, 0);
        cycles(1);
        chk("lat_valid", OutValid, 1);
        cycles(2);
        SPI_CLK = 1'b0;
        SPI_CS = 1'b1;
        cycles(6);
        chk("w1_data", OutData, 16'hA55A);
        chk("w1_rs", OutRS, 1);
        chk("w1_wc", WordCount, 1);
        chk("w1_ovf", Overflow, 0);
        chk("w1_ferr", FrameError, 0);
        pop_word();
        chk("w1_empty", OutValid, 0);

        // back-to-back command then data under one CS
        SPI_CS = 1'b0;
        send_bits(16'h002A, 1'b0, 16);
        send_bits(16'h1234, 1'b1, 16);
        SPI_CLK = 1'b0;
        SPI_CS = 1'b1;
        cycles(6);
        chk("b2b_wc", WordCount, 3);
        chk("b2b_d0", OutData, 16'h002A);
        chk("b2b_rs0", OutRS, 0);
        pop_word();
        chk("b2b_d1", OutData, 16'h1234);
        chk("b2b_rs1", OutRS, 1);
        pop_word();
        chk("b2b_empty", OutValid, 0);
        chk("b2b_ferr", FrameError, 0);

        // overflow: five words into a four-entry FIFO
        SPI_CS = 1'b0;
        for (int k = 1; k <= 5; k++) send_bits(16'(k), 1'b1, 16);
        SPI_CLK = 1'b0;
        SPI_CS = 1'b1;
        cycles(6);
        chk("ovf_flag", Overflow, 1);
        chk("ovf_wc", WordCount, 7);
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("ovf_head%0d", k), OutData, 32'(k));
            pop_word();
        end
        chk("ovf_drained", OutValid, 0);
        clear_err();
        chk("ovf_clear", Overflow, 0);

        // aborted frame after 7 bits
        SPI_CS = 1'b0;
        send_bits(16'hFFFF, 1'b1, 7);
        SPI_CLK = 1'b0;
        SPI_CS = 1'b1;
        cycles(6);
        chk("abort_ferr", FrameError, 1);
        chk("abort_nopush", OutValid, 0);
        chk("abort_wc", WordCount, 7);
        frame(16'hBEEF, 1'b0);
        chk("beef_data", OutData, 16'hBEEF);
        chk("beef_rs", OutRS, 0);
        chk("beef_wc", WordCount, 8);
        pop_word();
        clear_err();
        chk("abort_clear", FrameError, 0);

        // clocks while deselected are ignored
        SPI_CS = 1'b1;
        send_bits(16'hFFFF, 1'b1, 16);
        SPI_CLK = 1'b0;
        cycles(6);
        chk("desel_valid", OutValid, 0);
        chk("desel_wc", WordCount, 8);
        chk("desel_ferr", FrameError, 0);
        frame(16'h5A5A, 1'b1);
        chk("desel_align", OutData, 16'h5A5A);
        chk("desel_wc2", WordCount, 9);
        pop_word();

        // reset in the middle of a word with two words queued
        frame(16'h1111, 1'b1);
        frame(16'h2222, 1'b0);
        chk("pre_rst_wc", WordCount, 11);
        SPI_CS = 1'b0;
        send_bits(16'hFFFF, 1'b1, 9);
        Reset = 1'b1;
        #1;
        chk("mid_rst_valid", OutValid, 0);
        chk("mid_rst_wc", WordCount, 0);
        SPI_CLK = 1'b0;
        SPI_CS = 1'b1;
        SPI_MOSI = 1'b0;
        cycles(3);
        Reset = 1'b0;
        cycles(2);
        frame(16'h00FF, 1'b1);
        chk("post_rst_data", OutData, 16'h00FF);
        chk("post_rst_rs", OutRS, 1);
        chk("post_rst_wc", WordCount, 1);
        chk("post_rst_ferr", FrameError, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
